// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and the RAM port.
// Dirty victims are written back before refill; a flush writes back every dirty set and invalidates the array.
module dcache_wb #(
    parameter  int INDEX_W = 2,
    localparam int TAG_W   = 30 - INDEX_W,
    localparam int SETS    = 1 << INDEX_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    output logic        stallreq,
    input  logic        flush_i,
    output logic        flush_done_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    output logic        ram_ce_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_data_ready
);

    typedef enum logic [2:0] {IDLE, WB, FILL, FLUSH_SCAN, FLUSH_WB} state_t;

    typedef struct packed {
        logic [TAG_W-1:0]   tag;
        logic [INDEX_W-1:0] idx;
    } miss_t;

    localparam logic [INDEX_W-1:0] LAST = '1;

    state_t               state, next_state;
    miss_t                miss_q;
    logic [SETS-1:0]      valid, dirty;
    logic [TAG_W-1:0]     tag_arr  [SETS];
    logic [31:0]          data_arr [SETS];
    logic                 pend;
    logic [INDEX_W-1:0]   cnt;

    logic [INDEX_W-1:0]   idx, wb_idx;
    logic [TAG_W-1:0]     tag;
    logic                 hit, store_hit, scan_dirty;
    logic [31:0]          merged;
    logic                 unused_addr;

    assign idx         = mem_addr_i[INDEX_W+1:2];
    assign tag         = mem_addr_i[31:INDEX_W+2];
    assign unused_addr = ^mem_addr_i[1:0];
    assign hit         = valid[idx] && (tag_arr[idx] == tag);
    assign store_hit   = (state == IDLE) && mem_ce_i && mem_we_i && hit;
    assign scan_dirty  = valid[cnt] && dirty[cnt];
    assign wb_idx      = (state == FLUSH_WB) ? cnt : miss_q.idx;

    always_comb begin
        merged = data_arr[idx];
        for (int b = 0; b < 4; b++)
            if (mem_sel_i[b]) merged[8*b +: 8] = mem_data_i[8*b +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                // A pending flush wins over a miss; the miss is retried afterwards.
                if (pend)                        next_state = FLUSH_SCAN;
                else if (mem_ce_i && !hit)       next_state = (valid[idx] && dirty[idx]) ? WB : FILL;
            end
            WB:         if (ram_data_ready) next_state = FILL;
            FILL:       if (ram_data_ready) next_state = IDLE;
            FLUSH_SCAN: begin
                if (scan_dirty)         next_state = FLUSH_WB;
                else if (cnt == LAST)   next_state = IDLE;
            end
            FLUSH_WB:   if (ram_data_ready) next_state = (cnt == LAST) ? IDLE : FLUSH_SCAN;
            default:    next_state = IDLE;
        endcase
    end

    always_comb begin
        mem_data_o   = '0;
        stallreq     = 1'b1;
        flush_done_o = 1'b0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_sel_o    = 4'b0000;
        ram_addr_o   = '0;
        ram_data_o   = '0;
        case (state)
            IDLE: begin
                stallreq = rst && mem_ce_i && !hit;
                if (mem_ce_i && !mem_we_i && hit) mem_data_o = data_arr[idx];
            end
            WB, FLUSH_WB: begin
                ram_ce_o     = 1'b1;
                ram_we_o     = 1'b1;
                ram_sel_o    = 4'b1111;
                ram_addr_o   = {tag_arr[wb_idx], wb_idx, 2'b00};
                ram_data_o   = data_arr[wb_idx];
                flush_done_o = (state == FLUSH_WB) && ram_data_ready && (cnt == LAST);
            end
            FILL: begin
                ram_ce_o   = 1'b1;
                ram_sel_o  = 4'b1111;
                ram_addr_o = {miss_q.tag, miss_q.idx, 2'b00};
            end
            FLUSH_SCAN: flush_done_o = !scan_dirty && (cnt == LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid  <= '0;
            dirty  <= '0;
            pend   <= 1'b0;
            cnt    <= '0;
            miss_q <= '0;
        end else begin
            pend <= (pend | flush_i) & ~flush_done_o;
            if (store_hit) dirty[idx] <= 1'b1;
            case (state)
                IDLE: begin
                    if (pend)                  cnt    <= '0;
                    else if (mem_ce_i && !hit) miss_q <= {tag, idx};
                end
                FILL: if (ram_data_ready) begin
                    valid[miss_q.idx] <= 1'b1;
                    dirty[miss_q.idx] <= 1'b0;
                end
                FLUSH_SCAN: if (!scan_dirty) begin
                    valid[cnt] <= 1'b0;
                    dirty[cnt] <= 1'b0;
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                // The written-back set is already clean, so the scan moves straight past it.
                FLUSH_WB: if (ram_data_ready) begin
                    valid[cnt] <= 1'b0;
                    dirty[cnt] <= 1'b0;
                    if (cnt != LAST) cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == FILL && ram_data_ready) begin
            data_arr[miss_q.idx] <= ram_data_i;
            tag_arr[miss_q.idx]  <= miss_q.tag;
        end
        if (store_hit) data_arr[idx] <= merged;
    end

endmodule
